// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - priority interrupt controller with masked sticky sources; IRQ_AUTO_CLEAR_EN enables the per-source clear strobe
module irq_controller #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 3
) (
    input  logic             CLK,
    input  logic             CPU_Reset,
    input  logic [N_SRC-1:0] IRQ_SRC,
    input  logic             IRQ_MASK_WR,
    input  logic [7:0]       IRQ_MASK_DATA,
    input  logic             IRQ_ACK,
    input  logic             IRQ_RETI,
    output logic             IRQ,
    output logic [VEC_W-1:0] IRQ_VECTOR,
    output logic [N_SRC-1:0] IRQ_SRC_READ,
    output logic [N_SRC-1:0] IRQ_PENDING,
    output logic             IRQ_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [N_SRC-1:0]   mask_q;
    logic               vec_load;
    logic               ack_taken;

    // Bit 0 is the highest priority, so the lowest set bit wins arbitration.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
        lowest_set = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = VEC_W'(i);
            end
        end
    endfunction

    // Only the low N_SRC bits of the mask bus are meaningful.
    generate
        if (N_SRC < 8) begin : g_mask_unused
            logic unused_mask_bits;
            assign unused_mask_bits = ^IRQ_MASK_DATA[7:N_SRC];
        end
    endgenerate

    // Mask register; a write becomes visible to the pending register one cycle later.
    always_ff @(posedge CLK or negedge CPU_Reset) begin
        if (!CPU_Reset) begin
            mask_q <= '0;
        end else if (IRQ_MASK_WR) begin
            mask_q <= IRQ_MASK_DATA[N_SRC-1:0];
        end
    end

    // Pending status: sources qualified by the mask, re-sampled every cycle.
    always_ff @(posedge CLK or negedge CPU_Reset) begin
        if (!CPU_Reset) begin
            IRQ_PENDING <= '0;
        end else begin
            IRQ_PENDING <= IRQ_SRC & mask_q;
        end
    end

    // Vector is captured once when leaving IDLE and frozen until the next arbitration.
    always_ff @(posedge CLK or negedge CPU_Reset) begin
        if (!CPU_Reset) begin
            IRQ_VECTOR <= '0;
        end else if (vec_load) begin
            IRQ_VECTOR <= lowest_set(IRQ_PENDING);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge CPU_Reset) begin
        if (!CPU_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; ACK beats both withdrawal and a coincident RETI.
    always_comb begin
        state_d   = state_q;
        vec_load  = 1'b0;
        ack_taken = 1'b0;
        IRQ       = 1'b0;
        IRQ_BUSY  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|IRQ_PENDING) begin
                    state_d  = ST_REQ;
                    vec_load = 1'b1;
                end
            end
            ST_REQ: begin
                IRQ = 1'b1;
                if (IRQ_ACK) begin
                    state_d   = ST_SERVICE;
                    ack_taken = 1'b1;
                end else if (!IRQ_PENDING[IRQ_VECTOR]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                IRQ_BUSY = 1'b1;
                if (IRQ_RETI && !IRQ_ACK) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef IRQ_AUTO_CLEAR_EN
    // One-cycle one-hot clear strobe back to the acknowledged source.
    always_ff @(posedge CLK or negedge CPU_Reset) begin
        if (!CPU_Reset) begin
            IRQ_SRC_READ <= '0;
        end else if (ack_taken) begin
            IRQ_SRC_READ <= N_SRC'(1) << IRQ_VECTOR;
        end else begin
            IRQ_SRC_READ <= '0;
        end
    end
`else
    logic unused_ack_taken;
    assign unused_ack_taken = ack_taken;
    assign IRQ_SRC_READ     = '0;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - randomized scoreboard bench for irq_controller
module tb_irq_controller;

    localparam int N  = 4;
    localparam int VW = 3;
`ifdef IRQ_AUTO_CLEAR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          CPU_Reset;
    logic [N-1:0]  src;
    logic          mask_wr;
    logic [7:0]    mask_data;
    logic          ack;
    logic          reti;
    logic          irq;
    logic [VW-1:0] vec;
    logic [N-1:0]  src_read;
    logic [N-1:0]  pending;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    irq_controller #(.N_SRC(N), .VEC_W(VW)) dut (
        .CLK          (CLK),
        .CPU_Reset    (CPU_Reset),
        .IRQ_SRC      (src),
        .IRQ_MASK_WR  (mask_wr),
        .IRQ_MASK_DATA(mask_data),
        .IRQ_ACK      (ack),
        .IRQ_RETI     (reti),
        .IRQ          (irq),
        .IRQ_VECTOR   (vec),
        .IRQ_SRC_READ (src_read),
        .IRQ_PENDING  (pending),
        .IRQ_BUSY     (busy)
    );

    // Reference model: what the CPU should currently see, in behavioural terms.
    bit requesting = 1'b0;
    bit serving    = 1'b0;
    int m_vec  = 0;
    int m_mask = 0;
    int m_pend = 0;
    int m_read = 0;

    typedef struct {
        bit irq;
        bit busy;
        int vec;
        int rd;
        int pend;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int highest_priority(input int v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Advance the model across one rising edge using the inputs held during the last cycle.
    task automatic model_edge();
        int pend_next;
        int rd_next;
        pend_next = int'(src) & m_mask;
        rd_next   = 0;
        // the timer drops its flag on the edge that sees its clear strobe
        src = src & ~N'(m_read);
        if (!CPU_Reset) begin
            requesting = 1'b0;
            serving    = 1'b0;
            m_vec      = 0;
            m_mask     = 0;
            m_pend     = 0;
            m_read     = 0;
            return;
        end
        if (serving) begin
            if (reti && !ack) serving = 1'b0;
        end else if (requesting) begin
            if (ack) begin
                requesting = 1'b0;
                serving    = 1'b1;
                if (AUTO) rd_next = 1 << m_vec;
            end else if (m_pend[m_vec] == 1'b0) begin
                requesting = 1'b0;
            end
        end else if (m_pend != 0) begin
            requesting = 1'b1;
            m_vec      = highest_priority(m_pend);
        end
        if (mask_wr) m_mask = int'(mask_data) & ((1 << N) - 1);
        m_read = rd_next;
        m_pend = pend_next;
    endtask

    task automatic step(input bit do_reset = 1'b0);
        exp_t e;
        @(posedge CLK);
        #1;
        if (do_reset) begin
            CPU_Reset = 1'b0;
            #1;
            check("rst_irq", irq, 0);
            check("rst_busy", busy, 0);
            check("rst_vector", vec, 0);
            check("rst_src_read", src_read, 0);
            check("rst_pending", pending, 0);
        end
        model_edge();
        e.irq  = requesting;
        e.busy = serving;
        e.vec  = m_vec;
        e.rd   = m_read;
        e.pend = m_pend;
        exp_q.push_back(e);
        ack     = 1'b0;
        reti    = 1'b0;
        mask_wr = 1'b0;
    endtask

    // Monitor: compare every presented output cycle against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("irq", irq, e.irq);
            check("busy", busy, e.busy);
            check("src_read", src_read, e.rd);
            check("pending", pending, e.pend);
            if (e.irq) check("vector", vec, e.vec);
        end
    end

    task automatic wait_irq();
        int n = 0;
        while (irq !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (irq !== 1'b1) check("irq_wait_timeout", irq, 1);
    endtask

    task automatic write_mask(input logic [7:0] d);
        mask_wr   = 1'b1;
        mask_data = d;
        step();
    endtask

    task automatic serve(input bit sw_clear);
        wait_irq();
        repeat ($urandom_range(0, 2)) step();
        ack = 1'b1;
        step();
        repeat ($urandom_range(1, 3)) step();
        if (sw_clear) src = src & ~(N'(1) << m_vec);
        reti = 1'b1;
        step();
    endtask

    initial begin
        CPU_Reset = 1'b0;
        src       = '0;
        mask_wr   = 1'b0;
        mask_data = '0;
        ack       = 1'b0;
        reti      = 1'b0;
        #2;
        check("init_irq", irq, 0);
        check("init_busy", busy, 0);
        check("init_vector", vec, 0);
        check("init_src_read", src_read, 0);
        check("init_pending", pending, 0);
        step();
        step();
        CPU_Reset = 1'b1;

        // flag with everything masked, then enable source 0
        src = 4'b0001;
        repeat (3) step();
        write_mask(8'h01);
        serve(1'b1);

        // two sources served in priority order
        write_mask(8'h0F);
        src = 4'b0110;
        serve(1'b1);
        serve(1'b1);
        repeat (3) step();

        // higher-priority arrival while requesting does not re-vector
        src = 4'b0100;
        wait_irq();
        src = src | 4'b0001;
        repeat (3) step();
        serve(1'b1);
        serve(1'b1);
        repeat (3) step();

        // withdrawal by masking in REQ
        write_mask(8'h01);
        src = 4'b0001;
        wait_irq();
        write_mask(8'h00);
        repeat (4) step();
        write_mask(8'h0F);
        serve(1'b1);
        repeat (2) step();

        // ignored ACK in IDLE, ignored RETI in REQ, then reset in SERVICE
        ack = 1'b1;
        step();
        step();
        src = 4'b0010;
        wait_irq();
        reti = 1'b1;
        step();
        step();
        ack = 1'b1;
        step();
        step();
        step(1'b1);
        step();
        CPU_Reset = 1'b1;
        src = 4'b1111;
        repeat (3) step();

        // flag left set across RETI re-requests when nothing clears it
        src = 4'b1000;
        write_mask(8'h08);
        serve(1'b0);
        serve(1'b1);
        repeat (3) step();

        // randomized traffic
        write_mask(8'h0F);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) src = src | N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 59) == 0) src = src & ~N'(1 << $urandom_range(0, N - 1));
            if (serving && !AUTO && $urandom_range(0, 2) == 0) src = src & ~(N'(1) << m_vec);
            if ($urandom_range(0, 39) == 0) begin
                mask_wr   = 1'b1;
                mask_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0F;
            end
            ack  = requesting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            reti = serving ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 399) == 0) begin
                step(1'b1);
                CPU_Reset = 1'b1;
            end else begin
                step();
            end
        end

        step();
        step();
        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
